// File: rtl/ppu_pixel_fifo.sv
// PPU pixel pipeline: circular BG FIFO plus a shifting OBJ overlay, with priority
// mixing, fine-scroll discard and palette lookup to one registered 2-bit shade per pop.
module ppu_pixel_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ROW_PX  = 8,
  parameter int unsigned PX_W    = 2,
  parameter int unsigned LINE_PX = 160
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [2:0]                discard,
  input  logic                      bg_load,
  input  logic [PX_W*ROW_PX-1:0]    bg_planes,
  output logic                      bg_ready,
  input  logic                      obj_load,
  input  logic [PX_W*ROW_PX-1:0]    obj_planes,
  input  logic                      obj_pal,
  input  logic                      obj_prio,
  input  logic                      bg_en,
  input  logic                      obj_en,
  input  logic [2*(2**PX_W)-1:0]    bgp,
  input  logic [2*(2**PX_W)-1:0]    obp0,
  input  logic [2*(2**PX_W)-1:0]    obp1,
  input  logic                      px_en,
  output logic                      px_valid,
  output logic [1:0]                px_shade,
  output logic [7:0]                px_x,
  output logic                      line_done,
  output logic                      overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PX_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count, w_count_nxt;

  logic [PX_W-1:0] r_ov_idx  [ROW_PX];
  logic            r_ov_pal  [ROW_PX];
  logic            r_ov_prio [ROW_PX];
  logic [PX_W-1:0] w_ov_idx  [ROW_PX];
  logic            w_ov_pal  [ROW_PX];
  logic            w_ov_prio [ROW_PX];

  logic [PX_W-1:0] w_bg_row  [ROW_PX];
  logic [PX_W-1:0] w_obj_row [ROW_PX];

  logic [2:0]      r_disc;
  logic [7:0]      r_npx;
  logic            r_px_valid, r_line_done, r_overflow;
  logic [1:0]      r_px_shade;
  logic [7:0]      r_px_x;

  logic            w_load, w_pop, w_obj_ok, w_obj_win;
  logic [PX_W-1:0] w_b;
  logic [2*(2**PX_W)-1:0] w_opal;
  logic [1:0]      w_shade;

  assign bg_ready  = (r_count <= CW'(DEPTH - ROW_PX));
  assign w_load    = bg_load && bg_ready && !clr && !rst;
  assign w_pop     = px_en && (r_count != '0) && !r_line_done && !clr && !rst;
  assign w_obj_ok  = obj_load && (r_count >= CW'(ROW_PX));
  assign w_count_nxt = r_count + (w_load ? CW'(ROW_PX) : '0) - (w_pop ? CW'(1) : '0);

  // Pixel k of a row is the leftmost-first bit (MSB) gathered across all planes.
  always_comb begin
    for (int unsigned k = 0; k < ROW_PX; k++) begin
      w_bg_row[k]  = '0;
      w_obj_row[k] = '0;
      for (int unsigned p = 0; p < PX_W; p++) begin
        w_bg_row[k][p]  = bg_planes[p*ROW_PX + ROW_PX - 1 - k];
        w_obj_row[k][p] = obj_planes[p*ROW_PX + ROW_PX - 1 - k];
      end
    end
  end

  // Overlay next state: shift on pop first, then merge into the still-transparent slots.
  always_comb begin
    for (int unsigned k = 0; k < ROW_PX; k++) begin
      w_ov_idx[k]  = r_ov_idx[k];
      w_ov_pal[k]  = r_ov_pal[k];
      w_ov_prio[k] = r_ov_prio[k];
    end
    if (w_pop) begin
      for (int unsigned k = 0; k < ROW_PX - 1; k++) begin
        w_ov_idx[k]  = r_ov_idx[k+1];
        w_ov_pal[k]  = r_ov_pal[k+1];
        w_ov_prio[k] = r_ov_prio[k+1];
      end
      w_ov_idx[ROW_PX-1]  = '0;
      w_ov_pal[ROW_PX-1]  = 1'b0;
      w_ov_prio[ROW_PX-1] = 1'b0;
    end
    if (w_obj_ok) begin
      for (int unsigned k = 0; k < ROW_PX; k++) begin
        if (w_ov_idx[k] == '0) begin
          w_ov_idx[k]  = w_obj_row[k];
          w_ov_pal[k]  = obj_pal;
          w_ov_prio[k] = obj_prio;
        end
      end
    end
  end

  always_comb begin
    w_b       = bg_en ? r_mem[r_rd_ptr] : '0;
    w_obj_win = obj_en && (r_ov_idx[0] != '0) && !(r_ov_prio[0] && (w_b != '0));
    w_opal    = r_ov_pal[0] ? obp1 : obp0;
    w_shade   = w_obj_win ? w_opal[{r_ov_idx[0], 1'b0} +: 2]
                          : (bg_en ? bgp[{w_b, 1'b0} +: 2] : 2'b00);
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int unsigned k = 0; k < ROW_PX; k++)
        r_mem[r_wr_ptr + PW'(k)] <= w_bg_row[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      for (int unsigned k = 0; k < ROW_PX; k++) begin
        r_ov_idx[k]  <= '0;
        r_ov_pal[k]  <= 1'b0;
        r_ov_prio[k] <= 1'b0;
      end
      r_npx       <= '0;
      r_px_valid  <= 1'b0;
      r_px_shade  <= '0;
      r_px_x      <= '0;
      r_line_done <= 1'b0;
      r_disc      <= rst ? 3'd0 : discard;
      if (rst) r_overflow <= 1'b0;
    end else begin
      if (bg_load && !bg_ready) r_overflow <= 1'b1;
      if (w_load) r_wr_ptr <= r_wr_ptr + PW'(ROW_PX);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      for (int unsigned k = 0; k < ROW_PX; k++) begin
        r_ov_idx[k]  <= w_ov_idx[k];
        r_ov_pal[k]  <= w_ov_pal[k];
        r_ov_prio[k] <= w_ov_prio[k];
      end
      r_px_valid <= 1'b0;
      if (w_pop) begin
        if (r_disc != '0) begin
          r_disc <= r_disc - 3'd1;
        end else begin
          r_px_valid <= 1'b1;
          r_px_shade <= w_shade;
          r_px_x     <= r_npx;
          r_npx      <= r_npx + 8'd1;
          if (r_npx == 8'(LINE_PX - 1)) r_line_done <= 1'b1;
        end
      end
    end
  end

  assign px_valid  = r_px_valid;
  assign px_shade  = r_px_shade;
  assign px_x      = r_px_x;
  assign line_done = r_line_done;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Self-checking bench for ppu_pixel_fifo: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the pixel pipeline.
module tb_ppu_pixel_fifo;
  localparam int DEPTH = 16, ROW_PX = 8, LINE_PX = 160;

  logic clk = 1'b0;
  logic rst, clr, bg_load, obj_load, obj_pal, obj_prio, bg_en, obj_en, px_en;
  logic [2:0]  discard;
  logic [15:0] bg_planes, obj_planes;
  logic [7:0]  bgp, obp0, obp1;
  logic        bg_ready, px_valid, line_done, overflow;
  logic [1:0]  px_shade;
  logic [7:0]  px_x;

  always #5 clk = ~clk;

  ppu_pixel_fifo #(.DEPTH(DEPTH), .ROW_PX(ROW_PX), .PX_W(2), .LINE_PX(LINE_PX)) dut (
    .clk(clk), .rst(rst), .clr(clr), .discard(discard),
    .bg_load(bg_load), .bg_planes(bg_planes), .bg_ready(bg_ready),
    .obj_load(obj_load), .obj_planes(obj_planes), .obj_pal(obj_pal), .obj_prio(obj_prio),
    .bg_en(bg_en), .obj_en(obj_en), .bgp(bgp), .obp0(obp0), .obp1(obp1),
    .px_en(px_en), .px_valid(px_valid), .px_shade(px_shade), .px_x(px_x),
    .line_done(line_done), .overflow(overflow)
  );

  // Reference model
  typedef struct { int idx; bit pal; bit prio; } slot_t;
  int         q[$];
  slot_t      ov[ROW_PX];
  int         m_disc, m_npx;
  bit         m_ld, m_ovf, m_valid;
  logic [1:0] m_shade;
  logic [7:0] m_x;
  int         checks = 0, errors = 0;

  function automatic int row_px(logic [15:0] planes, int k);
    return int'({planes[15-k], planes[7-k]});
  endfunction

  function automatic bit m_ready();
    return (DEPTH - q.size()) >= ROW_PX;
  endfunction

  function automatic logic [1:0] mix(int bgi, slot_t s);
    int b;
    logic [7:0] pal;
    b   = bg_en ? bgi : 0;
    pal = s.pal ? obp1 : obp0;
    if (obj_en && s.idx != 0 && !(s.prio && b != 0)) return pal[2*s.idx +: 2];
    if (bg_en) return bgp[2*b +: 2];
    return 2'b00;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int k = 0; k < ROW_PX; k++) ov[k] = '{idx: 0, pal: 1'b0, prio: 1'b0};
    m_npx = 0; m_x = 8'd0; m_ld = 1'b0; m_valid = 1'b0; m_shade = 2'b00;
  endtask

  // Advance the model by one clock using the inputs currently applied, then step the DUT.
  task automatic tick();
    int pre, b;
    bit rdy;
    if (rst) begin
      model_clear(); m_disc = 0; m_ovf = 1'b0;
    end else if (clr) begin
      model_clear(); m_disc = int'(discard);
    end else begin
      pre = q.size();
      rdy = m_ready();
      m_valid = 1'b0;
      if (px_en && pre != 0 && !m_ld) begin
        slot_t s0;
        b  = q.pop_front();
        s0 = ov[0];
        for (int k = 0; k < ROW_PX - 1; k++) ov[k] = ov[k+1];
        ov[ROW_PX-1] = '{idx: 0, pal: 1'b0, prio: 1'b0};
        if (m_disc != 0) m_disc--;
        else begin
          m_valid = 1'b1;
          m_shade = mix(b, s0);
          m_x     = 8'(m_npx);
          m_npx++;
          if (m_npx == LINE_PX) m_ld = 1'b1;
        end
      end
      if (obj_load && pre >= ROW_PX)
        for (int k = 0; k < ROW_PX; k++)
          if (ov[k].idx == 0) ov[k] = '{idx: row_px(obj_planes, k), pal: obj_pal, prio: obj_prio};
      if (bg_load) begin
        if (rdy) for (int k = 0; k < ROW_PX; k++) q.push_back(row_px(bg_planes, k));
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; clr = 0; bg_load = 0; obj_load = 0; px_en = 0; discard = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    bg_planes = '0; obj_planes = '0; obj_pal = 0; obj_prio = 0;
    bg_en = 1; obj_en = 1; bgp = 8'hE4; obp0 = 8'h1B; obp1 = 8'hC0;
    do_reset();
    checks++;
    if (px_valid !== 1'b0 || bg_ready !== 1'b1 || overflow !== 1'b0 || line_done !== 1'b0 || px_x !== 8'd0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b ovf=%b done=%b x=%0d want 0 1 0 0 0",
               px_valid, bg_ready, overflow, line_done, px_x);
    end
  endtask

  task automatic test_basic();
    do_reset();
    bgp = 8'hE4; bg_en = 1; obj_en = 1;
    bg_planes = 16'h00FF; bg_load = 1; tick(); bg_load = 0;
    px_en = 1;
    for (int i = 0; i < ROW_PX; i++) begin
      tick();
      checks++;
      if (px_valid !== 1'b1 || px_shade !== 2'b01 || px_x !== 8'(i) || bg_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic[%0d]: valid=%b shade=%b x=%0d ready=%b want 1 01 %0d 1",
                 i, px_valid, px_shade, px_x, bg_ready, i);
      end
    end
    tick();
    checks++;
    if (px_valid !== 1'b0) begin
      errors++; $display("FAIL empty_stall: px_valid=%b want 0", px_valid);
    end
    px_en = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    bg_planes = 16'h33CC;
    bg_load = 1; tick(); tick();
    checks++;
    if (bg_ready !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL full: ready=%b ovf=%b want 0 0", bg_ready, overflow);
    end
    tick();
    checks++;
    if (overflow !== 1'b1 || bg_ready !== 1'b0) begin
      errors++; $display("FAIL drop_load: ovf=%b ready=%b want 1 0", overflow, bg_ready);
    end
    px_en = 1; tick();
    checks++;
    if (bg_ready !== 1'b0 || px_valid !== 1'b1 || q.size() != 15) begin
      errors++; $display("FAIL pop_load_full: ready=%b valid=%b want 0 1", bg_ready, px_valid);
    end
    bg_load = 0;
    for (int i = 0; i < 7; i++) tick();
    px_en = 0;
    checks++;
    if (bg_ready !== 1'b1) begin
      errors++; $display("FAIL ready_at_8: ready=%b want 1", bg_ready);
    end
    bg_load = 1; tick(); bg_load = 0;
    checks++;
    if (bg_ready !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL reload: ready=%b ovf=%b want 0 1", bg_ready, overflow);
    end
    clr = 1; tick(); clr = 0;
    checks++;
    if (overflow !== 1'b1 || bg_ready !== 1'b1 || px_x !== 8'd0) begin
      errors++; $display("FAIL clr_keeps_ovf: ovf=%b ready=%b x=%0d want 1 1 0", overflow, bg_ready, px_x);
    end
  endtask

  task automatic test_discard();
    do_reset();
    bgp = 8'hE4; bg_en = 1;
    discard = 3'd3; clr = 1; tick(); clr = 0; discard = 3'd0;
    bg_planes = 16'h0F33; bg_load = 1; tick(); bg_load = 0;
    px_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (px_valid !== 1'b0 || px_x !== 8'd0) begin
        errors++; $display("FAIL discard[%0d]: valid=%b x=%0d want 0 0", i, px_valid, px_x);
      end
    end
    tick();
    checks++;
    if (px_valid !== 1'b1 || px_shade !== 2'b01 || px_x !== 8'd0) begin
      errors++; $display("FAIL after_discard: valid=%b shade=%b x=%0d want 1 01 0", px_valid, px_shade, px_x);
    end
    px_en = 0;
  endtask

  task automatic test_obj();
    logic [1:0] exp2 [ROW_PX];
    bgp = 8'hE4; obp0 = 8'h1B; obp1 = 8'hC0; bg_en = 1; obj_en = 1;
    do_reset();
    bg_planes = 16'h0000; bg_load = 1; tick(); bg_load = 0;
    obj_planes = 16'h8080; obj_pal = 1; obj_prio = 0; obj_load = 1; tick(); obj_load = 0;
    px_en = 1; tick(); px_en = 0;
    checks++;
    if (px_valid !== 1'b1 || px_shade !== 2'b11) begin
      errors++; $display("FAIL obj_over_bg0: valid=%b shade=%b want 1 11", px_valid, px_shade);
    end
    do_reset();
    bg_planes = 16'h8000; bg_load = 1; tick(); bg_load = 0;
    obj_prio = 1; obj_load = 1; tick(); obj_load = 0; obj_prio = 0;
    px_en = 1; tick(); px_en = 0;
    checks++;
    if (px_valid !== 1'b1 || px_shade !== 2'b10) begin
      errors++; $display("FAIL bg_prio: valid=%b shade=%b want 1 10", px_valid, px_shade);
    end
    // obj_load while FIFO holds fewer than a row must be ignored
    do_reset();
    obj_planes = 16'hFFFF; obj_load = 1; tick(); obj_load = 0;
    bg_planes = 16'h0000; bg_load = 1; tick(); bg_load = 0;
    px_en = 1; tick(); px_en = 0;
    checks++;
    if (px_valid !== 1'b1 || px_shade !== 2'b00) begin
      errors++; $display("FAIL obj_ignored_low_count: valid=%b shade=%b want 1 00", px_valid, px_shade);
    end
    // Two overlapping objects: first opaque pixels win
    exp2 = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    do_reset();
    bg_planes = 16'h0000; bg_load = 1; tick(); bg_load = 0;
    obj_planes = 16'h2080; obj_pal = 0; obj_load = 1; tick();
    obj_planes = 16'hFFFF; obj_pal = 1; tick(); obj_load = 0;
    px_en = 1;
    for (int i = 0; i < ROW_PX; i++) begin
      tick();
      checks++;
      if (px_valid !== 1'b1 || px_shade !== exp2[i] || px_shade !== m_shade) begin
        errors++; $display("FAIL obj_merge[%0d]: shade=%b want %b", i, px_shade, exp2[i]);
      end
    end
    px_en = 0; obj_pal = 0;
  endtask

  task automatic test_line();
    int nval = 0, cyc = 0;
    do_reset();
    bg_planes = 16'h5A3C; px_en = 1;
    while (nval < LINE_PX && cyc < 400) begin
      bg_load = m_ready();
      tick(); cyc++;
      if (px_valid) begin
        checks++;
        if (px_x !== 8'(nval) || px_shade !== m_shade) begin
          errors++; $display("FAIL line_x[%0d]: x=%0d shade=%b want %0d %b", nval, px_x, px_shade, nval, m_shade);
        end
        nval++;
      end
    end
    bg_load = 0;
    checks++;
    if (nval != LINE_PX || line_done !== 1'b1 || px_x !== 8'd159) begin
      errors++; $display("FAIL line_done: n=%0d done=%b x=%0d want 160 1 159", nval, line_done, px_x);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (px_valid !== 1'b0 || line_done !== 1'b1) begin
        errors++; $display("FAIL past_line[%0d]: valid=%b done=%b want 0 1", i, px_valid, line_done);
      end
    end
    clr = 1; tick(); clr = 0; px_en = 0;
    checks++;
    if (line_done !== 1'b0 || bg_ready !== 1'b1 || px_x !== 8'd0) begin
      errors++; $display("FAIL clr_line: done=%b ready=%b x=%0d want 0 1 0", line_done, bg_ready, px_x);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(999) < 3);
      clr        = ($urandom_range(99) < 2);
      discard    = 3'($urandom_range(7));
      bg_load    = ($urandom_range(99) < 40);
      bg_planes  = 16'($urandom);
      obj_load   = ($urandom_range(99) < 20);
      obj_planes = 16'($urandom);
      obj_pal    = 1'($urandom);
      obj_prio   = 1'($urandom);
      px_en      = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 5) begin
        bg_en = ($urandom_range(9) != 0); obj_en = ($urandom_range(9) != 0);
        bgp = 8'($urandom); obp0 = 8'($urandom); obp1 = 8'($urandom);
      end
      tick();
      checks++;
      if (px_valid !== m_valid || (m_valid && px_shade !== m_shade) || px_x !== m_x ||
          line_done !== m_ld || overflow !== m_ovf || bg_ready !== m_ready()) begin
        errors++;
        $display("FAIL random[%0d]: v=%b s=%b x=%0d d=%b o=%b r=%b want v=%b s=%b x=%0d d=%b o=%b r=%b",
                 i, px_valid, px_shade, px_x, line_done, overflow, bg_ready,
                 m_valid, m_shade, m_x, m_ld, m_ovf, m_ready());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_disc = 0; m_ovf = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_overflow();
    test_discard();
    test_obj();
    test_line();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
